// File: rtl/mdc_input_splitter.sv
// mdc_input_splitter: splits a natural-order complex stream into x[k] / x[k+N/2] lane pairs for MDC stage 1
module mdc_input_splitter #(
    parameter int NB      = 8,
    parameter int N       = 16,
    parameter int NB_ADDR = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic                 i_sync,
    input  logic signed [NB-1:0] i_data_r,
    input  logic signed [NB-1:0] i_data_i,
    output logic                 o_valid,
    output logic                 o_first,
    output logic signed [NB-1:0] o_data1_r,
    output logic signed [NB-1:0] o_data1_i,
    output logic signed [NB-1:0] o_data2_r,
    output logic signed [NB-1:0] o_data2_i
);
    typedef enum logic {FILL, PAIR} state_t;
    localparam logic [NB_ADDR:0] HALF    = (NB_ADDR+1)'(N/2);
    localparam logic [NB_ADDR:0] HALF_M1 = (NB_ADDR+1)'(N/2-1);
    localparam logic [NB_ADDR:0] LAST    = (NB_ADDR+1)'(N-1);
    state_t               state;
    logic [NB_ADDR:0]     r_count;
    logic [NB-1:0]        mem_r [N/2];
    logic [NB-1:0]        mem_i [N/2];
    logic [NB_ADDR-1:0]   wr_addr;
    logic                 we;
    logic                 pair_acc;
    assign wr_addr  = i_sync ? '0 : r_count[NB_ADDR-1:0];
    assign we       = i_valid && (i_sync || state == FILL);
    assign pair_acc = i_valid && !i_sync && state == PAIR;
    // buffer is deliberately not reset; its contents are rewritten before each read
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem_r[wr_addr] <= i_data_r;
            mem_i[wr_addr] <= i_data_i;
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= FILL;
            r_count   <= '0;
            o_valid   <= 1'b0;
            o_first   <= 1'b0;
            o_data1_r <= '0;
            o_data1_i <= '0;
            o_data2_r <= '0;
            o_data2_i <= '0;
        end else begin
            o_valid <= pair_acc;
            o_first <= pair_acc && r_count == HALF;
            if (i_valid && i_sync) begin
                r_count <= {{NB_ADDR{1'b0}}, 1'b1};
                state   <= FILL;
            end else if (i_valid) begin
                r_count <= r_count + 1'b1;
                if (state == FILL && r_count == HALF_M1)
                    state <= PAIR;
                else if (state == PAIR && r_count == LAST)
                    state <= FILL;
            end
            // in PAIR the low address bits equal r_count - N/2
            if (pair_acc) begin
                o_data1_r <= mem_r[r_count[NB_ADDR-1:0]];
                o_data1_i <= mem_i[r_count[NB_ADDR-1:0]];
                o_data2_r <= i_data_r;
                o_data2_i <= i_data_i;
            end
        end
    end
endmodule

// File: doc/mdc_input_splitter.md
# mdc_input_splitter

Front-end lane splitter for the two-lane MDC FFT pipeline. It takes one serial complex stream, one sample per valid cycle and frames of `N` samples in natural order. It emits the aligned pairs `x[k]` and `x[k+N/2]` on two lanes, which is the format the first MDC butterfly stage consumes on its `data1`/`data2` inputs. It sits between the ADC/sample source and stage 1, and it produces the lane pairing that stage 1's butterfly expects.

## Interface
Parameters:
- `NB` — default 8 — bit width of each real/imaginary component (signed, passed through unchanged).
- `N` — default 16 — FFT frame length; power of two, ≥ 4.
- `NB_ADDR` — default 3 — buffer address width; must equal log2(`N`/2).

Ports:
- `i_clk` — in — 1 — clock. Single clock domain; all logic is rising-edge.
- `i_rst` — in — 1 — reset. Asynchronous, active-high.
- `i_valid` — in — 1 — input sample qualifier.
- `i_sync` — in — 1 — when high with `i_valid`, the sample is index 0 of a new frame.
- `i_data_r` — in — `NB` — input sample, real part (signed).
- `i_data_i` — in — `NB` — input sample, imaginary part (signed).
- `o_valid` — out — 1 — output pair qualifier.
- `o_first` — out — 1 — high with the first pair (k=0) of each frame.
- `o_data1_r`, `o_data1_i` — out — `NB` each — lane 1 = `x[k]`.
- `o_data2_r`, `o_data2_i` — out — `NB` each — lane 2 = `x[k+N/2]`.

## Operation
- State: `N/2`-entry complex buffer; sample counter `r_count` (log2(`N`) bits); FSM with two states, FILL and PAIR.
- **FILL** (`r_count` < `N/2`):
  - Each accepted sample (`i_valid`=1) is written to `buf[r_count]`, then `r_count` increments.
  - When `r_count` reaches `N/2`, the FSM goes to PAIR.
  - `o_valid`=0 throughout FILL.
- **PAIR** (`r_count` ≥ `N/2`):
  - Each accepted sample drives `o_data2` directly from the input.
  - `o_data1` is driven from `buf[r_count-N/2]`; `o_valid`=1.
  - `o_first`=1 when `r_count`=`N/2`.
  - After sample `N-1`, `r_count` wraps to 0 and the FSM returns to FILL.
- No arithmetic is performed. Data bits pass through bit-exact, with no growth, rounding or saturation.
- `i_valid`=0: counter, FSM and buffer hold; `o_valid`=0 and `o_first`=0 that cycle. Data outputs hold their last value.
- `i_sync`=1 with `i_valid`=1 in any state (frame resync):
  - The current partial frame is discarded.
  - The sample is written to `buf[0]`, `r_count` becomes 1, and the FSM enters FILL.
  - No pair is emitted for that sample.
  - `i_sync` without `i_valid` is ignored.
- `i_sync` is optional. Free-running frames are delimited by counter wrap alone.
- **Back-to-back frames:** the next frame's FILL writes `buf[0]` only after `buf[N/2-1]` has been read in the previous PAIR. No ping-pong buffer is needed, and full-rate input is sustained indefinitely.
- **Reset** (async, any time including mid-frame):
  - `r_count`=0, FSM=FILL.
  - `o_valid`=0, `o_first`=0, all `o_data*`=0.
  - Buffer contents are don't-care and are not reset.

## Timing
- All outputs are registered.
- A sample accepted at edge *e* in PAIR produces its pair, `o_valid` and `o_first` visible from *e* until *e*+1. Latency from the lane-2 sample is 1 cycle.
- The lane-1 sample `x[k]` leaves `N/2` accepted samples plus 1 cycle after it arrived.
- With continuous input, output pairs appear on the `N/2` cycles following the FILL phase, then `o_valid` is low for `N/2` cycles.
- **Throughput:** one input sample per cycle; average one pair per two cycles.
- On async reset assertion, outputs go to reset values immediately, without waiting for a clock edge.
- First frame after reset: the first pair appears one cycle after the `(N/2+1)`-th accepted sample.

## Test plan
- **Continuous frame:** `N`=16, continuous `i_valid`; samples r=0..15, i=-r.
  - Required: exactly 8 pairs on consecutive cycles, (k, k+8) for k=0..7, with imaginary parts (-k, -k-8).
  - `o_first` only with pair (0,8); first `o_valid` one cycle after the 9th sample edge.
- **Gapped input:** same frame with `i_valid` toggling 1,0,1,0,…
  - Required: identical 8 pairs in order.
  - `o_valid` is high only in cycles following an accepted PAIR-phase sample.
- **Mid-frame resync:** feed 12 samples, then `i_sync`+`i_valid` with value 100 followed by 15 samples 101..115.
  - Required: pairs (100,108)…(107,115).
  - No pair contains values from the aborted frame.
- **Reset mid-PAIR:** assert `i_rst` asynchronously between edges after the 3rd pair.
  - Required: `o_valid`, `o_first` and all data read 0 before the next edge.
  - The next 16 samples produce a clean frame.
- **Extremes and continuity:** back-to-back frames (3 frames, no gaps) with samples alternating -128 and 127 on both components.
  - Required: bit-exact pass-through and 24 pairs in order.
  - `o_first` asserted exactly 3 times, spaced 16 cycles apart.
